// File: rtl/prbs_pd_multi.sv
// Pattern-then-PRBS-15 symbol generator with an independent aligned-pattern
// repetition detector; both share the pattern and count latched on start.
module prbs_pd_multi #(
   parameter int          SYM_W    = 8,
   parameter int          PAT_SYMS = 4,
   parameter int          CNT_W    = 8,
   parameter logic [14:0] SEED     = 15'h7FFF
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start,
   input  logic                      stop,
   input  logic [SYM_W*PAT_SYMS-1:0] pattern_in,
   input  logic [CNT_W-1:0]          n,
   output logic [SYM_W-1:0]          out,
   output logic                      out_valid,
   output logic                      busy,
   input  logic [SYM_W-1:0]          det_in,
   input  logic                      det_valid,
   output logic [CNT_W-1:0]          match_count,
   output logic                      pattern_detected
);

   localparam int PW    = SYM_W * PAT_SYMS;
   localparam int IDX_W = (PAT_SYMS > 1) ? $clog2(PAT_SYMS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PAT  = 2'd1,
      S_PRBS = 2'd2
   } state_t;

   // One PRBS symbol: SYM_W LFSR steps, first output bit lands in the MSB.
   // Returns {next_lfsr, symbol}.
   function automatic logic [15+SYM_W-1:0] prbs_sym(input logic [14:0] seed);
      logic [14:0]      l;
      logic [SYM_W-1:0] s;
      logic             fb;
      l = seed;
      s = '0;
      for (int b = 0; b < SYM_W; b++) begin
         s[SYM_W-1-b] = l[14];
         fb           = l[14] ^ l[13];
         l            = {l[13:0], fb};
      end
      return {l, s};
   endfunction

   function automatic logic [SYM_W-1:0] pat_sym(input logic [PW-1:0] p,
                                                input logic [IDX_W-1:0] idx);
      logic [PW-1:0] sh;
      sh = p >> ((PAT_SYMS - 1 - int'(idx)) * SYM_W);
      return sh[SYM_W-1:0];
   endfunction

   state_t             state_r, state_s;
   logic [PW-1:0]      pat_r, pat_s;
   logic [CNT_W-1:0]   n_r, n_s;
   logic [14:0]        lfsr_r, lfsr_s;
   logic [IDX_W-1:0]   idx_r, idx_s;
   logic [CNT_W-1:0]   rep_r, rep_s;
   logic [SYM_W-1:0]   out_r, out_s;
   logic               out_valid_r, out_valid_s;
   logic               busy_r;

   logic [PW-1:0]      win_r, win_s, win_shift_s;
   logic [IDX_W-1:0]   phase_r, phase_s;
   logic [CNT_W-1:0]   mc_r, mc_s;
   logic               pd_r, pd_s;
   logic               armed_r, armed_s;
   logic               hit_s;

   logic [15+SYM_W-1:0] prbs_cur_s, prbs_seed_s;

   assign prbs_cur_s  = prbs_sym(lfsr_r);
   assign prbs_seed_s = prbs_sym(SEED);

   // Generator next-state and next-output logic.
   always_comb begin
      state_s     = state_r;
      pat_s       = pat_r;
      n_s         = n_r;
      lfsr_s      = lfsr_r;
      idx_s       = idx_r;
      rep_s       = rep_r;
      out_s       = out_r;
      out_valid_s = out_valid_r;
      if (start) begin
         pat_s       = pattern_in;
         n_s         = n;
         rep_s       = '0;
         out_valid_s = 1'b1;
         if (n == '0) begin
            state_s = S_PRBS;
            idx_s   = '0;
            out_s   = prbs_seed_s[SYM_W-1:0];
            lfsr_s  = prbs_seed_s[15+SYM_W-1:SYM_W];
         end else begin
            state_s = S_PAT;
            idx_s   = IDX_W'(1);
            out_s   = pattern_in[PW-1 -: SYM_W];
            lfsr_s  = SEED;
         end
      end else begin
         case (state_r)
            S_IDLE: begin
               out_s       = '0;
               out_valid_s = 1'b0;
            end
            S_PAT: begin
               if (stop) begin
                  state_s     = S_IDLE;
                  out_s       = '0;
                  out_valid_s = 1'b0;
               end else if (rep_r == n_r) begin
                  // all repetitions sent: first PRBS symbol follows seamlessly
                  state_s = S_PRBS;
                  out_s   = prbs_cur_s[SYM_W-1:0];
                  lfsr_s  = prbs_cur_s[15+SYM_W-1:SYM_W];
               end else begin
                  out_s = pat_sym(pat_r, idx_r);
                  if (idx_r == IDX_W'(PAT_SYMS - 1)) begin
                     idx_s = '0;
                     rep_s = rep_r + CNT_W'(1);
                  end else begin
                     idx_s = idx_r + IDX_W'(1);
                  end
               end
            end
            S_PRBS: begin
               if (stop) begin
                  state_s     = S_IDLE;
                  out_s       = '0;
                  out_valid_s = 1'b0;
               end else begin
                  out_s  = prbs_cur_s[SYM_W-1:0];
                  lfsr_s = prbs_cur_s[15+SYM_W-1:SYM_W];
               end
            end
            default: begin
               state_s     = S_IDLE;
               out_s       = '0;
               out_valid_s = 1'b0;
            end
         endcase
      end
   end

   assign win_shift_s = {win_r[PW-SYM_W-1:0], det_in};
   assign hit_s       = (win_shift_s == pat_r);

   // Detector next-state logic; mid-pattern beats hold the count.
   always_comb begin
      win_s   = win_r;
      phase_s = phase_r;
      mc_s    = mc_r;
      pd_s    = pd_r;
      armed_s = armed_r;
      if (start) begin
         mc_s    = '0;
         pd_s    = 1'b0;
         phase_s = '0;
         armed_s = 1'b1;
      end else if (det_valid) begin
         win_s = win_shift_s;
         if (mc_r == '0) begin
            mc_s    = hit_s ? CNT_W'(1) : '0;
            phase_s = '0;
         end else if (phase_r == IDX_W'(PAT_SYMS - 1)) begin
            phase_s = '0;
            if (hit_s) begin
               mc_s = (mc_r == {CNT_W{1'b1}}) ? mc_r : mc_r + CNT_W'(1);
            end else begin
               mc_s = '0;
            end
         end else begin
            phase_s = phase_r + IDX_W'(1);
         end
         if (armed_r && (n_r != '0) && (mc_s == n_r)) begin
            pd_s = 1'b1;
         end else begin
            pd_s = pd_r;
         end
      end else begin
         win_s = win_r;
      end
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= S_IDLE;
         pat_r       <= '0;
         n_r         <= '0;
         lfsr_r      <= SEED;
         idx_r       <= '0;
         rep_r       <= '0;
         out_r       <= '0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         win_r       <= '0;
         phase_r     <= '0;
         mc_r        <= '0;
         pd_r        <= 1'b0;
         armed_r     <= 1'b0;
      end else begin
         state_r     <= state_s;
         pat_r       <= pat_s;
         n_r         <= n_s;
         lfsr_r      <= lfsr_s;
         idx_r       <= idx_s;
         rep_r       <= rep_s;
         out_r       <= out_s;
         out_valid_r <= out_valid_s;
         busy_r      <= (state_s != S_IDLE);
         win_r       <= win_s;
         phase_r     <= phase_s;
         mc_r        <= mc_s;
         pd_r        <= pd_s;
         armed_r     <= armed_s;
      end
   end

   assign out              = out_r;
   assign out_valid        = out_valid_r;
   assign busy             = busy_r;
   assign match_count      = mc_r;
   assign pattern_detected = pd_r;

endmodule

// File: tb/tb_prbs_pd_multi.sv
// Directed self-checking bench for prbs_pd_multi (default parameters).
module tb_prbs_pd_multi;

   logic        CLK;
   logic        RST;
   logic        start;
   logic        stop;
   logic [31:0] pattern_in;
   logic [7:0]  n;
   logic [7:0]  out;
   logic        out_valid;
   logic        busy;
   logic [7:0]  det_in;
   logic        det_valid;
   logic [7:0]  match_count;
   logic        pattern_detected;

   logic        lb;
   logic [7:0]  ext_data;
   logic        ext_valid;

   int total;
   int bad;

   logic [7:0] exp_lb [10];
   logic [7:0] exp_rs [5];

   assign det_in    = lb ? out : ext_data;
   assign det_valid = lb ? out_valid : ext_valid;

   prbs_pd_multi dut (
      .CLK              (CLK),
      .RST              (RST),
      .start            (start),
      .stop             (stop),
      .pattern_in       (pattern_in),
      .n                (n),
      .out              (out),
      .out_valid        (out_valid),
      .busy             (busy),
      .det_in           (det_in),
      .det_valid        (det_valid),
      .match_count      (match_count),
      .pattern_detected (pattern_detected)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic ext_beat(input logic v, input logic [7:0] d);
      ext_valid = v;
      ext_data  = d;
      step();
      ext_valid = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; start = 1'b1; pattern_in = 32'hABCDEFCD; n = 8'd2;
      for (int i = 0; i < 3; i++) step();
      start = 1'b0;
      total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out: got %h want 00", out); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (pattern_detected !== 1'b0) begin bad++; $display("FAIL reset_pd: got %b want 0", pattern_detected); end
      total++; if (match_count !== 8'd0) begin bad++; $display("FAIL reset_mc: got %h want 00", match_count); end
      RST = 1'b0;
      step();
   endtask

   task automatic test_loopback();
      lb = 1'b1; pattern_in = 32'hABCDEFCD; n = 8'd2; start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         start = 1'b0;
         total++; if (out !== exp_lb[i] || out_valid !== 1'b1) begin
            bad++; $display("FAIL lb_out[%0d]: got %h/%b want %h/1", i, out, out_valid, exp_lb[i]);
         end
         total++; if (pattern_detected !== (i >= 8)) begin
            bad++; $display("FAIL lb_pd[%0d]: got %b want %b", i, pattern_detected, (i >= 8));
         end
         if (i == 0) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL lb_busy: got %b want 1", busy); end
         end
         if (i == 8) begin
            total++; if (match_count !== 8'd2) begin bad++; $display("FAIL lb_mc: got %h want 02", match_count); end
         end
      end
   endtask

   task automatic test_restart();
      start = 1'b1; stop = 1'b1; pattern_in = 32'h12345678; n = 8'd1;
      for (int i = 0; i < 5; i++) begin
         step();
         start = 1'b0; stop = 1'b0;
         total++; if (out !== exp_rs[i] || out_valid !== 1'b1) begin
            bad++; $display("FAIL rs_out[%0d]: got %h/%b want %h/1", i, out, out_valid, exp_rs[i]);
         end
         total++; if (pattern_detected !== (i >= 4)) begin
            bad++; $display("FAIL rs_pd[%0d]: got %b want %b", i, pattern_detected, (i >= 4));
         end
      end
   endtask

   task automatic test_rst_mid();
      RST = 1'b1;
      step();
      total++; if (out !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL rstmid_gen: got %h/%b/%b want 00/0/0", out, out_valid, busy);
      end
      total++; if (match_count !== 8'd0 || pattern_detected !== 1'b0) begin
         bad++; $display("FAIL rstmid_det: got %h/%b want 00/0", match_count, pattern_detected);
      end
      RST = 1'b0;
      step();
   endtask

   task automatic test_stop();
      lb = 1'b1; pattern_in = 32'hABCDEFCD; n = 8'd2; start = 1'b1;
      step(); start = 1'b0;
      step();
      step();
      total++; if (out !== 8'hEF) begin bad++; $display("FAIL stop_sym3: got %h want ef", out); end
      stop = 1'b1;
      step(); stop = 1'b0;
      total++; if (out_valid !== 1'b0 || out !== 8'h00 || busy !== 1'b0) begin
         bad++; $display("FAIL stop_idle: got %h/%b/%b want 00/0/0", out, out_valid, busy);
      end
      for (int i = 0; i < 6; i++) step();
      total++; if (pattern_detected !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL stop_pd: got %b/%b want 0/0", pattern_detected, out_valid);
      end
   endtask

   task automatic test_det_ext();
      lb = 1'b0; ext_valid = 1'b0; pattern_in = 32'hABCDEFCD; n = 8'd2; start = 1'b1;
      step(); start = 1'b0; stop = 1'b1;
      step(); stop = 1'b0;
      ext_beat(1'b1, 8'h11); ext_beat(1'b1, 8'hAB); ext_beat(1'b0, 8'h00);
      ext_beat(1'b1, 8'hCD); ext_beat(1'b1, 8'hEF);
      total++; if (match_count !== 8'd0) begin bad++; $display("FAIL ext_lead: got %h want 00", match_count); end
      ext_beat(1'b0, 8'h55); ext_beat(1'b1, 8'hCD);
      total++; if (match_count !== 8'd1 || pattern_detected !== 1'b0) begin
         bad++; $display("FAIL ext_first: got %h/%b want 01/0", match_count, pattern_detected);
      end
      ext_beat(1'b1, 8'hAB); ext_beat(1'b0, 8'h00); ext_beat(1'b1, 8'hCD); ext_beat(1'b1, 8'hEF);
      ext_beat(1'b0, 8'h00); ext_beat(1'b0, 8'hCD);
      total++; if (pattern_detected !== 1'b0) begin bad++; $display("FAIL ext_early: got %b want 0", pattern_detected); end
      ext_beat(1'b1, 8'hCD);
      total++; if (match_count !== 8'd2 || pattern_detected !== 1'b1) begin
         bad++; $display("FAIL ext_detect: got %h/%b want 02/1", match_count, pattern_detected);
      end
      ext_beat(1'b0, 8'h00); ext_beat(1'b0, 8'h11);
      total++; if (match_count !== 8'd2 || pattern_detected !== 1'b1) begin
         bad++; $display("FAIL ext_hold: got %h/%b want 02/1", match_count, pattern_detected);
      end
   endtask

   task automatic test_det_corrupt();
      lb = 1'b0; pattern_in = 32'hABCDEFCD; n = 8'd2; start = 1'b1;
      step(); start = 1'b0; stop = 1'b1;
      total++; if (match_count !== 8'd0 || pattern_detected !== 1'b0) begin
         bad++; $display("FAIL cor_clear: got %h/%b want 00/0", match_count, pattern_detected);
      end
      step(); stop = 1'b0;
      ext_beat(1'b1, 8'hAB); ext_beat(1'b1, 8'hCD); ext_beat(1'b1, 8'hEF); ext_beat(1'b1, 8'hCD);
      total++; if (match_count !== 8'd1) begin bad++; $display("FAIL cor_first: got %h want 01", match_count); end
      ext_beat(1'b1, 8'hAB); ext_beat(1'b1, 8'h00); ext_beat(1'b1, 8'hEF); ext_beat(1'b1, 8'hCD);
      total++; if (match_count !== 8'd0) begin bad++; $display("FAIL cor_drop: got %h want 00", match_count); end
      ext_beat(1'b1, 8'hAB); ext_beat(1'b1, 8'hCD); ext_beat(1'b1, 8'hEF); ext_beat(1'b1, 8'hCD);
      total++; if (match_count !== 8'd1 || pattern_detected !== 1'b0) begin
         bad++; $display("FAIL cor_resync: got %h/%b want 01/0", match_count, pattern_detected);
      end
   endtask

   task automatic test_n_zero();
      lb = 1'b1; pattern_in = 32'hABCDEFCD; n = 8'd0; start = 1'b1;
      step(); start = 1'b0;
      total++; if (out !== 8'hFF || out_valid !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL n0_first: got %h/%b/%b want ff/1/1", out, out_valid, busy);
      end
      step();
      total++; if (out !== 8'hFE) begin bad++; $display("FAIL n0_second: got %h want fe", out); end
      for (int i = 0; i < 12; i++) begin
         step();
         total++; if (pattern_detected !== 1'b0) begin
            bad++; $display("FAIL n0_pd[%0d]: got %b want 0", i, pattern_detected);
         end
      end
      stop = 1'b1;
      step(); stop = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL n0_stop: got %b want 0", busy); end
   endtask

   initial begin
      total = 0; bad = 0;
      exp_lb = '{8'hAB, 8'hCD, 8'hEF, 8'hCD, 8'hAB, 8'hCD, 8'hEF, 8'hCD, 8'hFF, 8'hFE};
      exp_rs = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF};
      RST = 1'b1; start = 1'b0; stop = 1'b0; pattern_in = 32'h0; n = 8'd0;
      lb = 1'b1; ext_data = 8'h00; ext_valid = 1'b0;
      test_reset();
      test_loopback();
      test_restart();
      test_rst_mid();
      test_stop();
      test_det_ext();
      test_det_corrupt();
      test_n_zero();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prbs_pd_multi.md
# prbs_pd_multi

Parametrised successor to the fixed 32-bit/8-bit pattern-then-PRBS block. It serialises a PAT_SYMS-symbol training pattern n times, then switches to a PRBS-15 payload stream until stopped. An independent detector on a separate input counts consecutive aligned pattern repetitions and flags when n are seen. It sits between link-training control and the serial lane, and can run in loopback with `det_in` driven from `out`.

## Interface
- SYM_W, 8, symbol width in bits (1..15)
- PAT_SYMS, 4, symbols per pattern (>=2)
- CNT_W, 8, width of repetition count n and match_count
- SEED, 15'h7FFF, PRBS-15 seed loaded on start (must be nonzero)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  load pattern_in/n and begin a burst (restarts if busy)
- stop  in  1  end the burst, return to IDLE
- pattern_in  in  SYM_W*PAT_SYMS  pattern; MS symbol is sent first
- n  in  CNT_W  pattern repetitions to send and to detect
- out  out  SYM_W  serial symbol, registered
- out_valid  out  1  out carries a symbol
- busy  out  1  generator not in IDLE
- det_in  in  SYM_W  symbol stream to check
- det_valid  in  1  det_in qualifier
- match_count  out  CNT_W  consecutive aligned pattern matches, saturating
- pattern_detected  out  1  sticky; match_count reached n

## Operation
- Reset: all outputs 0. State IDLE. Pattern register 0. Detector disarmed.
- Generator FSM: IDLE -> PAT -> PRBS -> IDLE.
- Accepting start in any state:
  - latch pattern_in and n, load LFSR with SEED, zero symbol index and repetition counter;
  - clear match_count and pattern_detected;
  - arm the detector.
- start with n==0: go straight to PRBS.
- start and stop in the same cycle: start wins.
- PAT: emit pattern symbols MS-first, PAT_SYMS per repetition. After n*PAT_SYMS symbols, continue seamlessly into PRBS on the next cycle.
- PRBS: polynomial x^15+x^14+1.
  - Each symbol = SYM_W LFSR steps.
  - Per step: output bit = lfsr[14], fb = lfsr[14]^lfsr[13], lfsr = {lfsr[13:0], fb}.
  - The first output bit is the symbol MSB.
- stop in PAT/PRBS: out=0, out_valid=0, IDLE on the next edge. stop in IDLE: ignored.
- Detector, on each det_valid beat:
  - shift det_in into a PAT_SYMS-symbol window; the compare uses the post-shift window;
  - track beats since last match with a phase counter;
  - hold all state when det_valid=0.
- Match rule:
  - if match_count==0 and the window equals the pattern: match_count=1, phase=0;
  - if match_count>0 and this is the PAT_SYMS-th beat since the last match: window==pattern increments (saturating at 2^CNT_W-1); otherwise match_count = (window==pattern) ? 1 : 0.
- pattern_detected:
  - sets when match_count reaches n, with n>=1 and the detector armed;
  - stays set until the next start or RST;
  - never sets when n==0 or before the first start.

## Timing
- start sampled at edge k: first symbol on out with out_valid=1 after edge k. Symbol i appears after edge k+i.
- busy=1 from edge k until the edge that returns the FSM to IDLE.
- Detector latency is 1: match_count and pattern_detected update on the edge that samples the completing det_valid beat.
- Loopback, n repetitions: pattern_detected rises after edge k+n*PAT_SYMS.
- RST mid-burst: every output is 0 on the next edge.

## Test plan
- RST held 3 cycles with start=1 -> out=0, out_valid=0, busy=0, pattern_detected=0, match_count=0.
- Defaults, pattern 32'hABCDEFCD, n=2, loopback -> out AB CD EF CD AB CD EF CD FF FE. pattern_detected rises after the 8th symbol is sampled; match_count=2.
- Same stimulus, stop asserted at the 3rd symbol -> out_valid=0 next cycle, busy=0, pattern_detected stays 0.
- Detector driven externally:
  - 0x11, then AB CD EF CD AB CD EF CD with det_valid gaps -> misaligned lead ignored, detection after the last valid beat;
  - corrupt the 6th symbol to 0x00 -> match_count drops to 0, then re-syncs to 1 at the next full pattern, no detection.
- start with n=0 -> out FF FE immediately, pattern_detected never sets.
- Restart mid-PRBS with start and stop together, new pattern 32'h12345678, n=1 -> out 12 34 56 78 FF. Flag is cleared, then set after 4 symbols.
